// File: rtl/clk_freq_checker.sv
// rtl/clk_freq_checker.sv - counts rising edges of an asynchronous clock over a fixed window
// and reports the count plus a pass/fail against an expected edge count.
`timescale 1ns/1ps
module clk_freq_checker #(
  parameter int WINDOW      = 1000,
  parameter int CNT_W       = 16,
  parameter int EXP_EDGES   = 16,
  parameter int TOL         = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             freq_ok,
  output logic             overflow
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic signed [CNT_W+1:0] EXP_S = (CNT_W+2)'(EXP_EDGES);
  localparam logic signed [CNT_W+1:0] TOL_S = (CNT_W+2)'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     prev;
  logic                     s;
  logic                     rise;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_r;
  logic [WIN_W-1:0]         win;

  logic [CNT_W-1:0]         cnt_fin;
  logic                     ovf_fin;
  logic                     ok_fin;
  logic signed [CNT_W+1:0]  diff;
  logic signed [CNT_W+1:0]  absd;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~prev;

  // Count for this cycle including any rise now, so the final window cycle is not lost.
  always_comb begin
    cnt_fin = cnt;
    ovf_fin = ovf_r;
    if (rise) begin
      if (&cnt) ovf_fin = 1'b1;
      else      cnt_fin = cnt + 1'b1;
    end
    diff   = $signed({2'b00, cnt_fin}) - EXP_S;
    absd   = (diff < 0) ? -diff : diff;
    ok_fin = !ovf_fin && (absd <= TOL_S);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sync       <= '0;
      prev       <= 1'b0;
      cnt        <= '0;
      ovf_r      <= 1'b0;
      win        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= '0;
      freq_ok    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      prev <= s;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            cnt   <= '0;
            ovf_r <= 1'b0;
            win   <= WIN_W'(WINDOW - 1);
            busy  <= 1'b1;
          end
        end
        ARM: state <= MEASURE;
        MEASURE: begin
          cnt   <= cnt_fin;
          ovf_r <= ovf_fin;
          win   <= win - 1'b1;
          if (win == '0) begin
            state      <= REPORT;
            busy       <= 1'b0;
            done       <= 1'b1;
            edge_count <= cnt_fin;
            overflow   <= ovf_fin;
            freq_ok    <= ok_fin;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_checker.sv
// tb/tb_clk_freq_checker.sv - directed bench for clk_freq_checker: 8/16 MHz counts,
// constant input, saturation, mid-run reset and ignored start pulses.
`timescale 1ns/1ps
module tb_clk_freq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic        sig8, sig16, lvl;
  logic [1:0]  mode;
  logic        sig_in;
  logic        busy, done, freq_ok, overflow;
  logic [15:0] edge_count;
  logic        busy2, done2, freq_ok2, overflow2;
  logic [3:0]  edge_count2;

  int checks = 0;
  int errors = 0;

  clk_freq_checker #(.WINDOW(1000), .CNT_W(16), .EXP_EDGES(16), .TOL(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .sig_in(sig_in), .busy(busy), .done(done),
    .edge_count(edge_count), .freq_ok(freq_ok), .overflow(overflow)
  );

  clk_freq_checker #(.WINDOW(1000), .CNT_W(4), .EXP_EDGES(16), .TOL(1), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .start(start2), .sig_in(sig16), .busy(busy2), .done(done2),
    .edge_count(edge_count2), .freq_ok(freq_ok2), .overflow(overflow2)
  );

  always #1 clk = ~clk;

  // Offsets keep sig_in edges off the integer-ns clock edges.
  initial begin sig8 = 1'b0; #0.3; forever #62.5 sig8 = ~sig8; end
  initial begin sig16 = 1'b0; #0.3; forever #31.25 sig16 = ~sig16; end

  assign sig_in = (mode == 2'd0) ? sig8 : (mode == 2'd1) ? sig16 : lvl;

  task automatic do_run(input bit repulse, output int lat, output int dones, output bit busy_ok);
    int k;
    lat = -1; dones = 0; busy_ok = 1'b1;
    @(negedge clk); start = 1'b1; k = 0;
    while (k < 1100) begin
      @(negedge clk); k++;
      start = repulse && (k % 100 == 0);
      if (done === 1'b1) begin
        dones++;
        if (lat < 0) lat = k;
      end
      if (k <= 1001 && busy !== 1'b1) busy_ok = 1'b0;
      if (k == 1002 && busy !== 1'b0) busy_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input int exp_cnt, input bit exp_ok);
    int lat, dones; bit bok;
    do_run(1'b0, lat, dones, bok);
    checks++; if (lat !== 1002) begin errors++; $display("FAIL %s latency got %0d want 1002", name, lat); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL %s done_count got %0d want 1", name, dones); end
    checks++; if (!bok) begin errors++; $display("FAIL %s busy_window got bad want 1..1001 high", name); end
    checks++; if (edge_count !== 16'(exp_cnt)) begin errors++; $display("FAIL %s edge_count got %0d want %0d", name, edge_count, exp_cnt); end
    checks++; if (freq_ok !== exp_ok) begin errors++; $display("FAIL %s freq_ok got %b want %b", name, freq_ok, exp_ok); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL %s overflow got %b want 0", name, overflow); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0; lvl = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
    checks++; if (edge_count !== 16'd0) begin errors++; $display("FAIL reset edge_count got %0d want 0", edge_count); end
    checks++; if (freq_ok !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset flags got ok=%b ovf=%b want 0 0", freq_ok, overflow); end
    checks++; if (busy2 !== 1'b0 || edge_count2 !== 4'd0) begin errors++; $display("FAIL reset dut4 got busy=%b cnt=%0d want 0 0", busy2, edge_count2); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_8mhz;
    mode = 2'd0;
    check_run("8mhz", 16, 1'b1);
    repeat (50) @(negedge clk);
    checks++; if (edge_count !== 16'd16) begin errors++; $display("FAIL 8mhz_held edge_count got %0d want 16", edge_count); end
  endtask

  task automatic test_16mhz;
    mode = 2'd1;
    check_run("16mhz", 32, 1'b0);
  endtask

  task automatic test_constant;
    mode = 2'd2; lvl = 1'b0;
    repeat (10) @(negedge clk);
    lvl = 1'b1;
    repeat (10) @(negedge clk);
    check_run("const_high", 0, 1'b0);
  endtask

  task automatic test_overflow;
    int k;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; k = 1;
    while (done2 !== 1'b1 && k < 1200) begin @(negedge clk); k++; end
    checks++; if (k !== 1002) begin errors++; $display("FAIL ovf latency got %0d want 1002", k); end
    checks++; if (edge_count2 !== 4'd15) begin errors++; $display("FAIL ovf edge_count got %0d want 15", edge_count2); end
    checks++; if (overflow2 !== 1'b1) begin errors++; $display("FAIL ovf overflow got %b want 1", overflow2); end
    checks++; if (freq_ok2 !== 1'b0) begin errors++; $display("FAIL ovf freq_ok got %b want 0", freq_ok2); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int dones;
    mode = 2'd0;
    check_run("pre_reset", 16, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (301) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst busy_before got %b want 1", busy); end
    rst = 1'b1;
    #0.5;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst busy_done got %b %b want 0 0", busy, done); end
    checks++; if (edge_count !== 16'd0 || freq_ok !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst outputs got cnt=%0d ok=%b ovf=%b want 0 0 0", edge_count, freq_ok, overflow); end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (1100) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst no_done got %0d active cycles want 0", dones); end
    check_run("post_reset", 16, 1'b1);
  endtask

  task automatic test_back_to_back;
    int lat, dones; bit bok;
    mode = 2'd0;
    do_run(1'b1, lat, dones, bok);
    checks++; if (lat !== 1002) begin errors++; $display("FAIL repulse latency got %0d want 1002", lat); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL repulse done_count got %0d want 1", dones); end
    checks++; if (!bok) begin errors++; $display("FAIL repulse busy_window got bad want 1..1001 high"); end
    checks++; if (edge_count !== 16'd16 || freq_ok !== 1'b1) begin errors++; $display("FAIL repulse result got cnt=%0d ok=%b want 16 1", edge_count, freq_ok); end
  endtask

  initial begin
    test_reset();
    test_8mhz();
    test_16mhz();
    test_constant();
    test_overflow();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
